// File: rtl/char_uart_rx.sv
// char_uart_rx: 8N1 serial character receiver feeding the block-matching checker.
//
// Each correctly framed character is presented on char_out together with a
// one-cycle char_valid strobe. A frame whose stop bit samples low is dropped.
// It raises a one-cycle frame_err strobe, and the receiver then waits for the
// line to return high before it looks for the next start bit.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (even, >= 4)
//   CNT_W         bit-timing counter width (2**CNT_W > CLKS_PER_BIT)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high; clears all state
//   rx          serial line, idle high, LSB first, asynchronous to clk
//   char_out    last correctly received character, held between frames
//   char_valid  one-cycle strobe: char_out updated this cycle
//   frame_err   one-cycle strobe: stop bit sampled low, frame discarded
module char_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] char_out,
  output logic       char_valid,
  output logic       frame_err
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t           state;
  logic             rx_meta;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;

  // Two-flop synchronizer. Both flops reset to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      char_out   <= '0;
      char_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      char_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        // Recheck the line at mid start bit. Clearing the counter here makes
        // every later full-bit count land at the middle of its bit.
        START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // Returning to IDLE on the stop sample lets a start bit that follows
        // the stop bit directly be accepted one cycle later.
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              char_out   <= shreg;
              char_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // A break or stuck-low line must not be read as a string of frames.
        WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
